// File: rtl/counter_pkg.sv
// Shared types for the counter / rate-meter pair.
package counter_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    MEASURE
  } rate_state_t;

endpackage

// File: rtl/window_timer.sv
// Periodic window timer: counts 0..WINDOW-1 while enabled, pulses tick on the
// last count, and parks at 0 whenever en is low.
module window_timer #(
  parameter int WINDOW = 256
) (
  input  logic clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int TW = $clog2(WINDOW);
  localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

  logic [TW-1:0] timer;

  // Free-running window count, cleared while disabled.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      timer <= '0;
    end else if (!en) begin
      timer <= '0;
    end else if (timer == LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign tick = en && (timer == LAST);

endmodule

// File: rtl/count_rate_meter.sv
// Count rate meter: samples count_in once per window and reports the
// modulo-2^CNT_W delta on a valid/ready port, with a sticky overrun flag.
// Optional peak tracker on rate_max when COUNT_RATE_MAX_EN is defined.
//
//   state   | meaning
//   IDLE    | measurement stopped, timer parked
//   PRIME   | first window running; its tick only captures prev
//   MEASURE | every tick produces a delta against prev
module count_rate_meter
  import counter_pkg::*;
#(
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             meas_en,
  input  logic             rate_ready,
  input  logic             ovr_clr,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overrun
`ifdef COUNT_RATE_MAX_EN
  ,output logic [CNT_W-1:0] rate_max
`endif
);

  rate_state_t state, state_nxt;
  logic        tick;
  logic        do_prime;
  logic        do_meas;
  logic        accept;
  logic        lost;
  cnt_t        prev;
  cnt_t        delta;

  window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk   (clk),
    .Reset (Reset),
    .en    (meas_en),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-tick actions; dropping meas_en abandons the window.
  always_comb begin
    state_nxt = state;
    do_prime  = 1'b0;
    do_meas   = 1'b0;
    if (!meas_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (tick) begin
                   do_prime  = 1'b1;
                   state_nxt = MEASURE;
                 end
        MEASURE: if (tick) do_meas = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign delta  = count_in - prev;
  assign accept = rate_valid && rate_ready;
  assign lost   = do_meas && rate_valid && !rate_ready;

  // Sample register advances on every tick, even when the result is dropped.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                  prev <= '0;
    else if (do_prime || do_meas) prev <= count_in;
  end

  // Result holding register; a new result may replace one being accepted.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
    end else if (do_meas && !lost) begin
      rate_out   <= delta;
      rate_valid <= 1'b1;
    end else if (accept) begin
      rate_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new loss beats a simultaneous clear.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)        overrun <= 1'b0;
    else if (lost)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

`ifdef COUNT_RATE_MAX_EN
  cnt_t max_base;
  assign max_base = ovr_clr ? '0 : rate_max;

  // Peak delta over all produced results, dropped ones included.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)        rate_max <= '0;
    else if (do_meas) rate_max <= (delta > max_base) ? delta : max_base;
    else if (ovr_clr) rate_max <= '0;
  end
`else
  // No peak tracker in this build.
`endif

endmodule

// File: tb/tb_count_rate_meter.sv
// Testbench for count_rate_meter (WINDOW=8): directed scenarios plus a random
// phase, all checked against a window-arithmetic reference model.
module tb_count_rate_meter;

  localparam int WINDOW = 8;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] count_in;
  logic        meas_en;
  logic        rate_ready;
  logic        ovr_clr;
  logic [15:0] rate_out;
  logic        rate_valid;
  logic        overrun;
`ifdef COUNT_RATE_MAX_EN
  logic [15:0] rate_max;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          run_len;
  logic [15:0] m_prev, m_out, m_max;
  logic        m_valid, m_ovr;

  count_rate_meter #(.WINDOW(WINDOW)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .count_in   (count_in),
    .meas_en    (meas_en),
    .rate_ready (rate_ready),
    .ovr_clr    (ovr_clr),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .overrun    (overrun)
`ifdef COUNT_RATE_MAX_EN
    ,.rate_max  (rate_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_len = 0;
    m_prev  = '0;
    m_out   = '0;
    m_max   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, phrased as window arithmetic:
  // the k-th full window of an enabled run ends when run_len = k*WINDOW-1,
  // window 0 only primes, later windows report count - prev.
  task automatic model_edge(input logic en, input logic [15:0] c,
                            input logic rdy, input logic clr);
    bit          tick, meas, lost;
    logic [15:0] d, base;
    tick = 0;
    meas = 0;
    if (en) begin
      tick = (run_len % WINDOW) == WINDOW - 1;
      meas = tick && (run_len / WINDOW) > 0;
    end
    d    = c - m_prev;
    lost = meas && m_valid && !rdy;
    if (meas && !lost) begin
      m_out   = d;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (lost)     m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    base = clr ? 16'd0 : m_max;
    if (meas)     m_max = (d > base) ? d : base;
    else if (clr) m_max = 16'd0;
    if (tick) m_prev = c;
    run_len = en ? run_len + 1 : 0;
  endtask

  task automatic check_all();
    chk("rate_out", 32'(rate_out), 32'(m_out));
    chk("rate_valid", 32'(rate_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef COUNT_RATE_MAX_EN
    chk("rate_max", 32'(rate_max), 32'(m_max));
`endif
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, check at the next negedge.
  task automatic step(input logic en, input logic [15:0] c,
                      input logic rdy, input logic clr);
    meas_en    = en;
    count_in   = c;
    rate_ready = rdy;
    ovr_clr    = clr;
    @(posedge clk);
    model_edge(en, c, rdy, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic flush();
    step(1'b0, 16'($urandom), 1'b1, 1'b1);
  endtask

  function automatic logic [15:0] pick(int i, logic [15:0] t0, logic [15:0] t1,
                                       logic [15:0] t2, logic [15:0] t3);
    if (i % WINDOW != WINDOW - 1) return 16'($urandom);
    case (i / WINDOW)
      0:       return t0;
      1:       return t1;
      2:       return t2;
      default: return t3;
    endcase
  endfunction

  initial begin
    logic [15:0] c;
    logic        en;
    Reset = 1'b1; meas_en = 1'b0; count_in = '0; rate_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    #1;
    chk("reset_rate_out", 32'(rate_out), 32'h0);
    chk("reset_valid", 32'(rate_valid), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    Reset = 1'b0;

    // 1: ramp +1 per clock, deltas of 8
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 16'(i), (i == 16), 1'b0);
      if (i == 7)  chk("t1_prime_no_valid", 32'(rate_valid), 32'h0);
      if (i == 15) begin
        chk("t1_rate", 32'(rate_out), 32'd8);
        chk("t1_valid", 32'(rate_valid), 32'h1);
      end
      if (i == 16) chk("t1_accepted", 32'(rate_valid), 32'h0);
      if (i == 23) chk("t1_rate2", 32'(rate_out), 32'd8);
    end
    flush();

    // 2: wrap-around 0xFFFE -> 0x0002
    for (int i = 0; i < 16; i++)
      step(1'b1, pick(i, 16'hFFFE, 16'h0002, 0, 0), 1'b0, 1'b0);
    chk("t2_wrap_rate", 32'(rate_out), 32'h4);
    chk("t2_no_overrun", 32'(overrun), 32'h0);
    flush();

    // 3: unaccepted result, second delta dropped
    for (int i = 0; i < 24; i++)
      step(1'b1, pick(i, 16'd100, 16'd108, 16'd113, 0), 1'b0, 1'b0);
    chk("t3_kept_rate", 32'(rate_out), 32'd8);
    chk("t3_overrun", 32'(overrun), 32'h1);
    step(1'b0, 16'($urandom), 1'b0, 1'b1);
    chk("t3_ovr_cleared", 32'(overrun), 32'h0);
    flush();

    // 4: tick coincides with transfer of the pending result
    for (int i = 0; i < 24; i++) begin
      step(1'b1, pick(i, 16'd200, 16'd208, 16'd211, 0), (i == 23), 1'b0);
      if (i >= 15) chk("t4_valid_held", 32'(rate_valid), 32'h1);
    end
    chk("t4_new_rate", 32'(rate_out), 32'd3);
    flush();

    // 5: one-cycle meas_en drop restarts with a prime, then async reset
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b0, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, pick(i, 16'd50, 16'd58, 0, 0), 1'b0, 1'b0);
      if (i == 7) chk("t5_reprime", 32'(rate_valid), 32'h0);
    end
    chk("t5_rate", 32'(rate_out), 32'd8);
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_rate_out", 32'(rate_out), 32'h0);
    chk("t5_rst_valid", 32'(rate_valid), 32'h0);
    chk("t5_rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    Reset = 1'b0;

    // 6: deltas 8, 20, 5 with ready high
    for (int i = 0; i < 32; i++)
      step(1'b1, pick(i, 16'd0, 16'd8, 16'd28, 16'd33), 1'b1, 1'b0);
    chk("t6_last_rate", 32'(rate_out), 32'd5);
`ifdef COUNT_RATE_MAX_EN
    chk("t6_rate_max", 32'(rate_max), 32'd20);
    step(1'b0, 16'($urandom), 1'b1, 1'b1);
    chk("t6_max_cleared", 32'(rate_max), 32'h0);
`endif
    flush();

    // random phase
    c  = 16'($urandom);
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 60) == 0) en = ~en;
      if ($urandom_range(0, 200) == 0) c = 16'($urandom);
      else c = c + 16'($urandom_range(0, 12));
      step(en, c, 1'($urandom_range(0, 1)), ($urandom_range(0, 25) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
